// File: rtl/pc_fetch_pkg.sv
// Shared constants for the instruction-fetch front end: default word width,
// default reset vector and the fetch state encoding.
package pc_fetch_pkg;

  localparam int unsigned WORD_LENGTH          = 32;
  localparam int unsigned DEFAULT_RESET_VECTOR = 0;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

endpackage

// File: rtl/pc_fetch_pc_reg.sv
// Program-counter register: N-bit load-enabled register with synchronous
// active-low reset to RESET_VECTOR.
module pc_reg
  import pc_fetch_pkg::*;
#(
  parameter int unsigned  N            = WORD_LENGTH,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;

  always_comb begin
    pc_d = ld ? d : pc_q;
  end

  // NOTE: clocked state is written only with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_VECTOR;
    else      pc_q <= pc_d;
  end

  assign q = pc_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding word reads
// and holds one fetched instruction for decode. PC_FETCH_COUNT_EN adds fetch_count.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int unsigned  N            = WORD_LENGTH,
  parameter logic [N-1:0] RESET_VECTOR = N'(DEFAULT_RESET_VECTOR),
  parameter logic [N-1:0] INC          = N'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         br_en,
  input  logic [N-1:0] br_target,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ready,
  input  logic [N-1:0] instr_in,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] pc_out,
  output logic         instr_valid
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [N-1:0] fetch_count
`endif
);

  logic [1:0]   state_q, state_d;
  logic         valid_q, valid_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] pc_out_q, pc_out_d;

  logic [N-1:0] pc;
  logic [N-1:0] pc_next;
  logic         pc_ld;
  logic         accept;
  logic         slot_blocked;

  pc_reg #(
    .N            (N),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .ld  (pc_ld),
    .d   (pc_next),
    .q   (pc)
  );

  // A full slot that downstream refuses must not trigger a new read.
  assign slot_blocked = valid_q && stall;
  assign mem_req      = (state_q == ST_REQ) && !slot_blocked;
  assign mem_addr     = pc;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    pc_ld    = 1'b0;
    pc_next  = pc;
    accept   = 1'b0;

    if (br_en) begin
      pc_ld   = 1'b1;
      pc_next = br_target;
      valid_d = 1'b0;
      state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          valid_d = valid_q && stall;
        end
        ST_REQ: begin
          if (slot_blocked) begin
            state_d = ST_HOLD;
          end else if (mem_ready) begin
            accept = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            state_d = ST_REQ;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (accept) begin
      instr_d  = instr_in;
      pc_out_d = pc;
      valid_d  = 1'b1;
      pc_ld    = 1'b1;
      pc_next  = pc + INC;
    end
  end

  // NOTE: the slot data registers are reset too, because decode sees
  // instr_out/pc_out as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

`ifdef PC_FETCH_COUNT_EN
  logic [N-1:0] count_q, count_d;

  // Saturating count of accepted fetches; a branch leaves it untouched.
  always_comb begin
    count_d = count_q;
    if (accept && (count_q != '1)) count_d = count_q + N'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed steps followed by random traffic,
// all compared against a behavioural model of the fetch rules.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  localparam int unsigned N  = WORD_LENGTH;
  localparam int unsigned NW = 4;

  logic         clk = 1'b0;
  logic         rst, stall, br_en, mem_ready;
  logic [N-1:0] br_target, instr_in;
  logic         mem_req, instr_valid;
  logic [N-1:0] mem_addr, instr_out, pc_out;

  logic          w_rst, w_mem_ready;
  logic [NW-1:0] w_instr_in, w_mem_addr, w_instr_out, w_pc_out;
  logic          w_mem_req, w_instr_valid;

`ifdef PC_FETCH_COUNT_EN
  logic [N-1:0]  fetch_count;
  logic [NW-1:0] w_fetch_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the fetch unit should look like right now.
  logic [N-1:0] m_pc, m_instr, m_slot_pc, m_count;
  bit           m_warm, m_hold, m_valid;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_en       (br_en),
    .br_target   (br_target),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .instr_in    (instr_in),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
`ifdef PC_FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  pc_fetch #(
    .N            (NW),
    .RESET_VECTOR (4'd14)
  ) dut_w (
    .clk         (clk),
    .rst         (w_rst),
    .stall       (1'b0),
    .br_en       (1'b0),
    .br_target   (4'h0),
    .mem_req     (w_mem_req),
    .mem_addr    (w_mem_addr),
    .mem_ready   (w_mem_ready),
    .instr_in    (w_instr_in),
    .instr_out   (w_instr_out),
    .pc_out      (w_pc_out),
    .instr_valid (w_instr_valid)
`ifdef PC_FETCH_COUNT_EN
    ,
    .fetch_count (w_fetch_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    if (!rst) begin
      m_pc = '0; m_instr = '0; m_slot_pc = '0; m_count = '0;
      m_warm = 0; m_hold = 0; m_valid = 0;
    end else if (br_en) begin
      m_pc = br_target; m_valid = 0; m_hold = 0; m_warm = 1;
    end else if (!m_warm) begin
      m_warm = 1;
      if (!stall) m_valid = 0;
    end else if (m_hold) begin
      if (!stall) begin m_hold = 0; m_valid = 0; end
    end else if (m_valid && stall) begin
      m_hold = 1;
    end else if (mem_ready) begin
      m_instr = instr_in; m_slot_pc = m_pc; m_valid = 1;
      m_pc = m_pc + 1;
      if (m_count != '1) m_count = m_count + 1;
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check_model();
    bit exp_req;
    exp_req = m_warm && !m_hold && !(m_valid && stall);
    check("mem_req", mem_req, exp_req);
    if (exp_req) check("mem_addr", mem_addr, m_pc);
    check("instr_valid", instr_valid, m_valid);
    if (m_valid) begin
      check("instr_out", instr_out, m_instr);
      check("pc_out", pc_out, m_slot_pc);
    end
`ifdef PC_FETCH_COUNT_EN
    check("fetch_count", fetch_count, m_count);
`endif
  endtask

  // Called at a falling edge with inputs set: check, clock, land on next falling edge.
  task automatic tick();
    #1 check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    logic [NW-1:0] wrap_exp [4];
    wrap_exp = '{4'd14, 4'd15, 4'd0, 4'd1};

    rst = 0; stall = 0; br_en = 0; mem_ready = 0; br_target = '0; instr_in = '0;
    w_rst = 0; w_mem_ready = 0; w_instr_in = '0;
    @(posedge clk);
    model_edge();
    @(negedge clk);

    // Reset state
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
`ifdef PC_FETCH_COUNT_EN
    check("rst_count", fetch_count, 32'h0);
`endif

    // Reset landing mid-request
    rst = 1; tick(); tick();
    rst = 0; tick();
    check("midreq_mem_req", mem_req, 1'b0);
    check("midreq_valid", instr_valid, 1'b0);
    rst = 1;
    #1 check("first_cycle_req", mem_req, 1'b0);
    tick();
    stall = 0; mem_ready = 1; instr_in = 32'h100;
    #1 check("second_cycle_req", mem_req, 1'b1);
    check("second_cycle_addr", mem_addr, 32'h0);

    // Zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      instr_in = 32'h100 + 32'(i);
      tick();
      check("stream_instr", instr_out, 32'h100 + 32'(i));
      check("stream_pc", pc_out, 32'(i));
      check("stream_valid", instr_valid, 1'b1);
    end

    // Slot full and stalled: no reads, slot frozen
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      instr_in = $urandom;
      #1 check("stall_mem_req", mem_req, 1'b0);
      tick();
      check("stall_instr", instr_out, 32'h103);
      check("stall_pc", pc_out, 32'h3);
    end
    stall = 0; instr_in = 32'hBAD;
    #1 check("hold_mem_req", mem_req, 1'b0);
    tick();
    check("hold_drain_valid", instr_valid, 1'b0);
    #1 check("resume_req", mem_req, 1'b1);
    check("resume_addr", mem_addr, 32'h4);

    // Branch flush with memory data in the same cycle
    instr_in = 32'h104; tick();
    check("pre_br_pc", pc_out, 32'h4);
    br_en = 1; br_target = 32'h40; instr_in = 32'hDEAD; tick();
    br_en = 0;
    check("br_flush_valid", instr_valid, 1'b0);
    #1 check("br_addr", mem_addr, 32'h40);
    instr_in = 32'h140; tick();
    check("br_pc_out", pc_out, 32'h40);
    check("br_instr_out", instr_out, 32'h140);
    instr_in = 32'h141; tick();
`ifdef PC_FETCH_COUNT_EN
    check("count_after_branch", fetch_count, 32'd7);
`endif

    // PC wrap on the 4-bit instance
    mem_ready = 0;
    w_rst = 1; w_mem_ready = 1; w_instr_in = 4'h5;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_pc_out", w_pc_out, wrap_exp[i]);
      check("wrap_valid", w_instr_valid, 1'b1);
    end
    repeat (16) tick();
    check("wrap_last_pc", w_pc_out, 4'd1);
`ifdef PC_FETCH_COUNT_EN
    check("count_saturated", w_fetch_count, 4'd15);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      br_en     = ($urandom_range(0, 11) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      instr_in  = $urandom;
      br_target = $urandom;
      tick();
    end
    rst = 1; stall = 0; br_en = 0; mem_ready = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
